// File: rtl/audiodac_ds_decim.sv
// Third-order CIC decimator that turns a 1-bit delta-sigma stream into 16-bit PCM,
// with a ready/ack output handshake and a sticky overrun flag.
module audiodac_ds_decim (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [1:0]  osr_i,
  input  logic        ds_i,
  output logic [15:0] data_o,
  output logic        rdy_o,
  input  logic        ack_i,
  output logic        ovr_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e      state_q;
  logic [1:0]  osr_q;
  logic [7:0]  cnt_q;
  logic        flush_q;
  logic [24:0] int1_q, int2_q, int3_q;
  logic [24:0] dly1_q, dly2_q, dly3_q;
  logic [15:0] data_q;
  logic        rdy_q;
  logic        ovr_q;

  logic [24:0]        step_d;
  logic [24:0]        int1_d, int2_d, int3_d;
  logic [24:0]        diff1_d, diff2_d, diff3_d;
  logic signed [24:0] scaled_d;
  logic [7:0]         cnt_max_d;
  logic               tick_d;
  logic [15:0]        pcm_d;

  function automatic logic [15:0] sat16(input logic signed [24:0] v);
    logic [15:0] r;
    if (v > 25'sd32767) begin
      r = 16'h7FFF;
    end else if (v < 25'sh1FF_8000) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  // Filter datapath: integrators see the current input bit so a tick includes it.
  always_comb begin
    step_d  = ds_i ? 25'h000_0001 : 25'h1FF_FFFF;
    int1_d  = int1_q + step_d;
    int2_d  = int2_q + int1_d;
    int3_d  = int3_q + int2_d;
    diff1_d = int3_d - dly1_q;
    diff2_d = diff1_d - dly2_q;
    diff3_d = diff2_d - dly3_q;
    case (osr_q)
      2'd0: begin
        cnt_max_d = 8'd31;
        scaled_d  = $signed(diff3_d);
      end
      2'd1: begin
        cnt_max_d = 8'd63;
        scaled_d  = $signed(diff3_d) >>> 3;
      end
      2'd2: begin
        cnt_max_d = 8'd127;
        scaled_d  = $signed(diff3_d) >>> 6;
      end
      2'd3: begin
        cnt_max_d = 8'd255;
        scaled_d  = $signed(diff3_d) >>> 9;
      end
      default: begin
        cnt_max_d = 8'd31;
        scaled_d  = $signed(diff3_d);
      end
    endcase
    tick_d = (cnt_q == cnt_max_d);
    pcm_d  = sat16(scaled_d);
  end

  // Control FSM, filter state and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      osr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      flush_q <= 1'b0;
      int1_q  <= 25'd0;
      int2_q  <= 25'd0;
      int3_q  <= 25'd0;
      dly1_q  <= 25'd0;
      dly2_q  <= 25'd0;
      dly3_q  <= 25'd0;
      data_q  <= 16'd0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (!en_i) begin
      state_q <= ST_IDLE;
      osr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      flush_q <= 1'b0;
      int1_q  <= 25'd0;
      int2_q  <= 25'd0;
      int3_q  <= 25'd0;
      dly1_q  <= 25'd0;
      dly2_q  <= 25'd0;
      dly3_q  <= 25'd0;
      data_q  <= 16'd0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FLUSH;
          osr_q   <= osr_i;
        end
        ST_FLUSH, ST_RUN: begin
          int1_q <= int1_d;
          int2_q <= int2_d;
          int3_q <= int3_d;
          if (tick_d) begin
            cnt_q  <= 8'd0;
            dly1_q <= int3_d;
            dly2_q <= diff1_d;
            dly3_q <= diff2_d;
            // The first two results still carry the start-up transient.
            if (state_q == ST_FLUSH) begin
              if (flush_q) begin
                state_q <= ST_RUN;
              end else begin
                flush_q <= 1'b1;
              end
            end else if (!rdy_q || ack_i) begin
              data_q <= pcm_d;
              rdy_q  <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (ack_i) begin
              rdy_q <= 1'b0;
            end else begin
              rdy_q <= rdy_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_o = data_q;
  assign rdy_o  = rdy_q;
  assign ovr_o  = ovr_q;

endmodule
